// File: rtl/clk_en_ctrl.sv
// Clock-enable controller: generates one-cycle cpu_en pulses either free-running
// at a selectable divided rate (RUN) or one per step-button press (STEP/HOLD),
// and counts issued pulses in a saturating 16-bit event counter.
module clk_en_ctrl #(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_req,
    input  logic        step_btn,
    input  logic [1:0]  div_sel,
    input  logic        clr_cnt,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic [15:0] ev_cnt
);

    // Base period in clk cycles; must be a multiple of 4, at least 4, below 2^28.
    localparam logic [27:0] P_FULL = 28'(CLK_HZ / TICK_HZ);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        HOLD = 2'b11
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [27:0] cnt_reg;
    logic [27:0] cnt_next;
    logic        step_q_reg;
    logic [1:0]  sel_q_reg;
    logic        cpu_en_reg;
    logic        pulse_next;
    logic [15:0] ev_cnt_reg;
    logic [27:0] p_sel;
    logic        step_rise;
    logic        sel_change;

    assign step_rise  = step_btn & ~step_q_reg;
    assign sel_change = (div_sel != sel_q_reg);

    // Selected pulse period for the current rate select.
    always_comb begin
        p_sel = P_FULL;
        case (div_sel)
            2'b00:   p_sel = P_FULL;
            2'b01:   p_sel = P_FULL >> 1;
            2'b10:   p_sel = P_FULL >> 2;
            default: p_sel = 28'd1;
        endcase
    end

    // Next-state, counter and pulse decision.
    always_comb begin
        state_next = state_reg;
        cnt_next   = 28'd0;
        pulse_next = 1'b0;
        case (state_reg)
            IDLE: begin
                // run_req wins over a simultaneous step edge
                if (run_req) begin
                    state_next = RUN;
                end else if (step_rise) begin
                    state_next = STEP;
                end
            end
            RUN: begin
                if (!run_req) begin
                    // leaving RUN suppresses any pulse due on this edge
                    state_next = IDLE;
                end else if (sel_change) begin
                    // rate change restarts the period with no pulse
                    cnt_next = 28'd0;
                end else if (cnt_reg == p_sel - 28'd1) begin
                    cnt_next   = 28'd0;
                    pulse_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 28'd1;
                end
            end
            STEP: begin
                pulse_next = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                // wait for button release so one press yields one pulse
                if (!step_btn) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counter, input history and registered pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 28'd0;
            step_q_reg <= 1'b0;
            sel_q_reg  <= 2'b00;
            cpu_en_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            step_q_reg <= step_btn;
            sel_q_reg  <= div_sel;
            cpu_en_reg <= pulse_next;
        end
    end

    // Saturating count of issued pulses; clear takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ev_cnt_reg <= 16'd0;
        end else if (clr_cnt) begin
            ev_cnt_reg <= 16'd0;
        end else if (pulse_next && (ev_cnt_reg != 16'hFFFF)) begin
            ev_cnt_reg <= ev_cnt_reg + 16'd1;
        end
    end

    assign cpu_en = cpu_en_reg;
    assign state  = state_reg;
    assign ev_cnt = ev_cnt_reg;

endmodule

// File: tb/tb_clk_en_ctrl.sv
// Self-checking bench for clk_en_ctrl with P = 8: directed scenarios plus
// randomized stimulus compared every cycle against a behavioural model.
module tb_clk_en_ctrl;

    localparam int P = 8;

    logic        clk;
    logic        rst;
    logic        run_req;
    logic        step_btn;
    logic [1:0]  div_sel;
    logic        clr_cnt;
    logic        cpu_en;
    logic [1:0]  state;
    logic [15:0] ev_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int pulses_seen = 0;

    // Behavioural model: mode names, edges since period restart, history.
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HOLD = 3;
    int m_mode;
    int m_age;
    int m_prev_btn;
    int m_prev_sel;
    int m_ev;
    int m_pulse;

    clk_en_ctrl #(.CLK_HZ(8), .TICK_HZ(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .run_req  (run_req),
        .step_btn (step_btn),
        .div_sel  (div_sel),
        .clr_cnt  (clr_cnt),
        .cpu_en   (cpu_en),
        .state    (state),
        .ev_cnt   (ev_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int period_of(input int sel);
        case (sel)
            0:       return P;
            1:       return P / 2;
            2:       return P / 4;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_age = 0; m_prev_btn = 0; m_prev_sel = 0;
        m_ev = 0; m_pulse = 0;
    endtask

    // One rising edge of the model, using the inputs present at that edge.
    task automatic model_edge();
        int sel;
        sel = int'(div_sel);
        m_pulse = 0;
        case (m_mode)
            M_IDLE: begin
                if (run_req) begin
                    m_mode = M_RUN; m_age = 0;
                end else if (step_btn && m_prev_btn == 0) begin
                    m_mode = M_STEP;
                end
            end
            M_RUN: begin
                if (!run_req) begin
                    m_mode = M_IDLE;
                end else if (sel != m_prev_sel) begin
                    m_age = 0;
                end else begin
                    m_age++;
                    if (m_age % period_of(sel) == 0) m_pulse = 1;
                end
            end
            M_STEP: begin
                m_pulse = 1; m_mode = M_HOLD;
            end
            default: begin
                if (!step_btn) m_mode = M_IDLE;
            end
        endcase
        if (clr_cnt) m_ev = 0;
        else if (m_pulse == 1 && m_ev < 65535) m_ev++;
        m_prev_btn = int'(step_btn);
        m_prev_sel = sel;
    endtask

    // Advance one clock, step the model, compare all outputs just after the edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        if (cpu_en === 1'b1) pulses_seen++;
        check_val({tag, ".cpu_en"}, 32'(cpu_en), 32'(m_pulse));
        check_val({tag, ".state"},  32'(state),  32'(m_mode));
        check_val({tag, ".ev_cnt"}, 32'(ev_cnt), 32'(m_ev));
    endtask

    initial begin
        int base;
        rst = 1'b0; run_req = 1'b0; step_btn = 1'b0; div_sel = 2'b00; clr_cnt = 1'b0;
        model_reset();
        #12;
        check_val("reset.cpu_en", 32'(cpu_en), 32'd0);
        check_val("reset.state",  32'(state),  32'd0);
        check_val("reset.ev_cnt", 32'(ev_cnt), 32'd0);
        rst = 1'b1;
        tick("idle");
        $display("scenario reset done");

        // Free run at full period: pulses after edges 8,16,24,32,40.
        run_req = 1'b1; div_sel = 2'b00;
        tick("run_entry");
        for (int i = 0; i < 40; i++) tick("run_p8");
        check_val("run_p8.total", 32'(ev_cnt), 32'd5);
        check_val("run_p8.in_run", 32'(state), 32'd1);
        $display("scenario run_p8 ev_cnt=%0d", ev_cnt);

        // Single step: held 10 cycles, one pulse.
        run_req = 1'b0;
        tick("to_idle");
        base = pulses_seen;
        step_btn = 1'b1;
        for (int i = 0; i < 10; i++) tick("step_hold");
        step_btn = 1'b0;
        for (int i = 0; i < 3; i++) tick("step_rel");
        check_val("step.pulses", 32'(pulses_seen - base), 32'd1);
        check_val("step.ev", 32'(ev_cnt), 32'd6);
        step_btn = 1'b1; tick("step2"); tick("step2");
        step_btn = 1'b0; tick("step2"); tick("step2");
        check_val("step2.ev", 32'(ev_cnt), 32'd7);
        $display("scenario step ev_cnt=%0d", ev_cnt);

        // P/4 then switch to every-cycle mid-count.
        clr_cnt = 1'b1; tick("clr");
        clr_cnt = 1'b0;
        run_req = 1'b1; div_sel = 2'b10;
        for (int i = 0; i < 4; i++) tick("run_p2");
        div_sel = 2'b11;
        tick("sel_switch");
        check_val("sel_switch.no_pulse", 32'(cpu_en), 32'd0);
        for (int i = 0; i < 6; i++) tick("run_p1");
        check_val("run_p1.pulse", 32'(cpu_en), 32'd1);
        $display("scenario rate_switch ev_cnt=%0d", ev_cnt);

        // run_req and step rise together; then drop run_req when cnt==7.
        run_req = 1'b0; step_btn = 1'b0; div_sel = 2'b00;
        tick("idle2"); tick("idle2");
        run_req = 1'b1; step_btn = 1'b1;
        tick("prio");
        check_val("prio.state", 32'(state), 32'd1);
        for (int i = 0; i < 7; i++) tick("prio_run");
        run_req = 1'b0;
        tick("drop");
        check_val("drop.no_pulse", 32'(cpu_en), 32'd0);
        check_val("drop.state", 32'(state), 32'd0);
        step_btn = 1'b0;
        tick("drop_after");
        $display("scenario priority_drop ev_cnt=%0d", ev_cnt);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) run_req = ~run_req;
            if ($urandom_range(0, 29) == 0) div_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)  step_btn = ~step_btn;
            clr_cnt = ($urandom_range(0, 49) == 0);
            tick("rand");
        end
        clr_cnt = 1'b0;
        $display("scenario random ev_cnt=%0d", ev_cnt);

        // Asynchronous reset mid-RUN with step held across it.
        run_req = 1'b1; div_sel = 2'b01; step_btn = 1'b1;
        tick("pre_rst"); tick("pre_rst"); tick("pre_rst");
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_val("async_rst.cpu_en", 32'(cpu_en), 32'd0);
        check_val("async_rst.state",  32'(state),  32'd0);
        check_val("async_rst.ev_cnt", 32'(ev_cnt), 32'd0);
        run_req = 1'b0;
        #2;
        rst = 1'b1;
        tick("post_rst");
        check_val("post_rst.step", 32'(state), 32'd2);
        tick("post_rst");
        check_val("post_rst.pulse", 32'(cpu_en), 32'd1);
        step_btn = 1'b0;
        tick("post_rst"); tick("post_rst");
        $display("scenario async_reset ev_cnt=%0d", ev_cnt);

        // Saturate ev_cnt, confirm it holds on a further step, then clear.
        clr_cnt = 1'b1; tick("sat_clr");
        clr_cnt = 1'b0;
        run_req = 1'b1; div_sel = 2'b11;
        for (int i = 0; i < 65540; i++) tick("sat_run");
        run_req = 1'b0;
        tick("sat_idle");
        check_val("sat.full", 32'(ev_cnt), 32'hFFFF);
        step_btn = 1'b1; tick("sat_step"); tick("sat_step");
        step_btn = 1'b0; tick("sat_step"); tick("sat_step");
        check_val("sat.hold", 32'(ev_cnt), 32'hFFFF);
        clr_cnt = 1'b1; tick("sat_clr2");
        clr_cnt = 1'b0;
        check_val("sat.cleared", 32'(ev_cnt), 32'd0);
        $display("scenario saturate ev_cnt=%0d", ev_cnt);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_en_ctrl.md
CLK_EN_CTRL -- requirements
Module: clk_en_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100000000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1, base enable rate in Hz; base period P = CLK_HZ/TICK_HZ, legal only if P >= 4, P divisible by 4, P < 2^28.
REQ-003 clk  input  1  single system clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately, release takes effect at the next clk edge.
REQ-005 run_req  input  1  level; 1 requests free-running enable pulses.
REQ-006 step_btn  input  1  level, already synchronous and debounced; each rising edge requests one enable pulse.
REQ-007 div_sel  input  2  rate select: 00 -> P, 01 -> P/2, 10 -> P/4, 11 -> 1 cycle; the selected value is P_sel.
REQ-008 clr_cnt  input  1  synchronous clear of ev_cnt.
REQ-009 cpu_en  output  1  registered one-cycle clock-enable pulse for the downstream controller datapath.
REQ-010 state  output  2  current FSM state: IDLE=00, RUN=01, STEP=10, HOLD=11.
REQ-011 ev_cnt  output  16  number of cpu_en pulses issued, saturating.

Function
REQ-012 Internal 28-bit counter cnt and registered copies step_q (previous step_btn) and sel_q (previous div_sel); step_rise = step_btn & ~step_q.
REQ-013 IDLE: run_req=1 -> RUN with cnt<=0; else step_rise=1 -> STEP; else stay; run_req has priority over step_rise on the same edge.
REQ-014 RUN: cnt increments by 1 each edge; at an edge where cnt==P_sel-1 and run_req=1, cnt<=0 and cpu_en<=1 for exactly the following cycle.
REQ-015 RUN: first pulse is high during the cycle after the P_sel-th edge following RUN entry; pulses then repeat every P_sel cycles; P_sel=1 gives cpu_en=1 every cycle.
REQ-016 RUN: run_req=0 at an edge -> IDLE, cnt<=0, no pulse on that edge even if cnt==P_sel-1.
REQ-017 RUN: step_rise is ignored; step_q still updates every cycle in every state.
REQ-018 div_sel != sel_q at an edge in RUN -> cnt<=0, no pulse on that edge; counting restarts with the new P_sel.
REQ-019 STEP: cpu_en<=1 (high during the next cycle), -> HOLD unconditionally; exactly one pulse per STEP entry.
REQ-020 HOLD: stay while step_btn=1; step_btn=0 -> IDLE; run_req is ignored in STEP and HOLD.
REQ-021 cpu_en is 0 in every cycle not explicitly set by REQ-014 or REQ-019; it is never high in two consecutive cycles except in RUN with P_sel=1.
REQ-022 ev_cnt: clr_cnt=1 -> 0 (priority over increment); else +1 on each edge that sets cpu_en; holds at 16'hFFFF once reached.
REQ-023 cnt never exceeds P_sel-1; in IDLE, STEP and HOLD cnt is held at 0.

Reset
REQ-024 rst=0 asynchronously forces state=IDLE, cnt=0, cpu_en=0, ev_cnt=0, step_q=0, sel_q=00, regardless of clk.
REQ-025 Reset asserted mid-RUN or mid-HOLD aborts the operation with no residual pulse; after release the block is in IDLE and a step_btn held high from before reset produces one step_rise on the first clk edge after release.

Verification (CLK_HZ=8, TICK_HZ=1, so P=8)
REQ-026 rst released, run_req=1, div_sel=00 for 40 cycles -> state=RUN, cpu_en pulses on the cycles after the 8th, 16th, 24th, 32nd, 40th edges after entry, ev_cnt=5.
REQ-027 IDLE, step_btn high for 10 cycles then low -> exactly one cpu_en pulse, state sequence IDLE->STEP->HOLD (10 cycles)->IDLE, ev_cnt=1; a second press gives ev_cnt=2.
REQ-028 RUN with div_sel=10 (P_sel=2), switch to 11 mid-count -> one edge with cnt cleared and no pulse, then cpu_en=1 every cycle.
REQ-029 IDLE with run_req and step_btn rising on the same edge -> RUN entered, no step pulse; run_req dropped at cnt==7 -> IDLE, no pulse.
REQ-030 rst asserted between clk edges during RUN -> all outputs 0 and state=IDLE immediately; ev_cnt forced to 0xFFFF via 65535+ steps stays 0xFFFF on the next step and clr_cnt=1 returns it to 0.
